input_capture: RTL

INPUT_CAPTURE -- requirements
Module: input_capture

---
 rtl/input_capture.sv | 125 ++++++++++++
 1 files changed

// File: rtl/input_capture.sv
// Debounced switch/button capture for a small register-file front panel.
// Raw switches and buttons are double-synchronized, then one FSM debounces
// a single button at a time, applies its action once, and waits for a clean
// release before accepting the next press.
module input_capture #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw_data,
  input  logic [2:0] sw_addr,
  input  logic       btn_wr,
  input  logic       btn_ra,
  input  logic       btn_rb,
  output logic [2:0] addrW,
  output logic [3:0] datW,
  output logic       regwrite,
  output logic [2:0] addRa,
  output logic [2:0] addRb,
  output logic       led
);

  // Terminal count for both the press and release windows.
  localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, ACT, RELEASE} state_t;
  typedef enum logic [1:0] {BTN_WR, BTN_RA, BTN_RB} btn_t;

  logic [9:0]  raw;
  logic [9:0]  s1_q, s2_q;
  logic [3:0]  data_s;
  logic [2:0]  addr_s;
  logic        wr_s, ra_s, rb_s, any_s;
  logic        held;
  state_t      state_q;
  btn_t        btn_q;
  logic [15:0] cnt_q;

  assign raw = {sw_data, sw_addr, btn_wr, btn_ra, btn_rb};

  // Two-flop synchronizer on every raw input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  assign {data_s, addr_s, wr_s, ra_s, rb_s} = s2_q;
  assign any_s = wr_s | ra_s | rb_s;

  // Level of whichever button was latched on entry to DEBOUNCE.
  always_comb begin
    held = 1'b0;
    case (btn_q)
      BTN_WR:  held = wr_s;
      BTN_RA:  held = ra_s;
      BTN_RB:  held = rb_s;
      default: held = 1'b0;
    endcase
  end

  // Debounce FSM; the action is registered on the edge that enters ACT,
  // so the outputs change exactly when the ACT cycle begins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      btn_q    <= BTN_WR;
      cnt_q    <= '0;
      addrW    <= '0;
      datW     <= '0;
      regwrite <= 1'b0;
      addRa    <= '0;
      addRb    <= '0;
      led      <= 1'b0;
    end else begin
      regwrite <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (any_s) begin
            if (wr_s)      btn_q <= BTN_WR;
            else if (ra_s) btn_q <= BTN_RA;
            else           btn_q <= BTN_RB;
            state_q <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!held) begin
            state_q <= IDLE;
          end else if (cnt_q == DEB_LAST) begin
            state_q <= ACT;
            led     <= ~led;
            case (btn_q)
              BTN_WR: begin
                addrW    <= addr_s;
                datW     <= data_s;
                regwrite <= 1'b1;
              end
              BTN_RA:  addRa <= addr_s;
              default: addRb <= addr_s;
            endcase
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ACT: begin
          cnt_q   <= '0;
          state_q <= RELEASE;
        end
        RELEASE: begin
          // Any button activity restarts the quiet window.
          if (any_s)                 cnt_q <= '0;
          else if (cnt_q == DEB_LAST) state_q <= IDLE;
          else                       cnt_q <= cnt_q + 16'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
